midi_byte_writer: RTL

MIDI_BYTE_WRITER -- requirements
Module: midi_byte_writer

---
 rtl/midi_byte_writer_if.sv | 10 +
 rtl/midi_byte_writer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/midi_byte_writer_if.sv
// Byte handshake between a MIDI byte producer and the serial writer.
// The producer holds byteValue/byteValid; the writer answers with byteReady.
interface midi_byte_writer_if;
  logic [7:0] byteValue;
  logic       byteValid;
  logic       byteReady;

  modport master (output byteValue, output byteValid, input byteReady);
  modport slave  (input byteValue, input byteValid, output byteReady);
endinterface

// File: rtl/midi_byte_writer.sv
// MIDI serial transmitter: a 4-entry byte FIFO feeding a start/8-data/stop
// frame generator, with back-to-back frames and no gaps between them.
module midi_byte_writer #(
  parameter int CLKS_PER_BIT = 3200,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  midi_byte_writer_if.slave        byteIn,
  output logic                     MIDI_TX,
  output logic                     isBusy,
  output logic [2:0]               fifoCount
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [11:0] LastCnt  = 12'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  FullCnt  = 3'(FIFO_DEPTH);

  state_t      state;
  logic [11:0] bitCnt;
  logic [2:0]  bitIdx;
  logic [7:0]  shiftReg;
  logic [7:0]  fifoMem [4];
  logic [1:0]  wrPtr;
  logic [1:0]  rdPtr;
  logic        push;
  logic        pop;
  logic        bitEnd;
  logic        fifoEmpty;

  assign fifoEmpty        = (fifoCount == 3'd0);
  assign byteIn.byteReady = ~rst & (fifoCount != FullCnt);
  assign push             = byteIn.byteValid & byteIn.byteReady;
  assign bitEnd           = (bitCnt == LastCnt);
  // A byte leaves the FIFO only when a new frame begins, from idle or straight out of a stop bit.
  assign pop              = ~fifoEmpty & ((state == IDLE) | ((state == STOP) & bitEnd));
  assign isBusy           = (state != IDLE) | ~fifoEmpty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= 2'd0;
      rdPtr     <= 2'd0;
      fifoCount <= 3'd0;
      for (int i = 0; i < 4; i++) fifoMem[i] <= 8'd0;
    end else begin
      if (push) begin
        fifoMem[wrPtr] <= byteIn.byteValue;
        wrPtr          <= wrPtr + 2'd1;
      end
      if (pop) rdPtr <= rdPtr + 2'd1;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 3'd1;
        2'b01:   fifoCount <= fifoCount - 3'd1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // Frame sequencer; MIDI_TX is registered and already carries the next bit's level on each boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bitCnt   <= 12'd0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'd0;
      MIDI_TX  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bitCnt <= 12'd0;
          if (pop) begin
            state    <= START;
            shiftReg <= fifoMem[rdPtr];
            MIDI_TX  <= 1'b0;
          end
        end
        START: begin
          if (bitEnd) begin
            state    <= DATA;
            bitCnt   <= 12'd0;
            bitIdx   <= 3'd0;
            MIDI_TX  <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
          end else begin
            bitCnt <= bitCnt + 12'd1;
          end
        end
        DATA: begin
          if (bitEnd) begin
            bitCnt <= 12'd0;
            if (bitIdx == 3'd7) begin
              state   <= STOP;
              MIDI_TX <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              MIDI_TX  <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
            end
          end else begin
            bitCnt <= bitCnt + 12'd1;
          end
        end
        STOP: begin
          if (bitEnd) begin
            bitCnt <= 12'd0;
            if (pop) begin
              state    <= START;
              shiftReg <= fifoMem[rdPtr];
              MIDI_TX  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            bitCnt <= bitCnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
